// File: rtl/tansig_table_loader.sv
// Writer side of the tansig lookup table: AXI-stream loader into on-chip RAM plus a 1-cycle read port.
// Optional build macro TANSIG_LOADER_CHECK_EN adds per-beat range and monotonic-order checks.
module tansig_table_loader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 201,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_load,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              table_ready,
    output logic              load_err
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_cnt, wr_cnt_nxt;
    logic              beat, wr_en, at_end, bad;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    assign s_axis_tready = (state == LOAD);
    assign table_ready   = (state == DONE);
    assign load_err      = (state == ERR);
    assign beat          = s_axis_tvalid & s_axis_tready;
    assign at_end        = (wr_cnt == LAST_IDX);

`ifdef TANSIG_LOADER_CHECK_EN
    localparam logic [DATA_W-1:0] ONE_F = DATA_W'(32'h3F800000);
    logic [DATA_W-1:0] prev;

    // Entry 0 has no predecessor, so only the range test applies to it.
    assign bad = beat && (s_axis_tdata[DATA_W-1] || (s_axis_tdata > ONE_F) ||
                          ((wr_cnt != '0) && (s_axis_tdata < prev)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        prev <= '0;
        else if (wr_en) prev <= s_axis_tdata;
    end
`else
    assign bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wr_cnt <= '0;
        end else begin
            state  <= state_nxt;
            wr_cnt <= wr_cnt_nxt;
        end
    end

    // wr_cnt never advances past the last index, so writes stay inside the RAM.
    always_comb begin
        state_nxt  = state;
        wr_cnt_nxt = wr_cnt;
        wr_en      = 1'b0;
        if (start_load) begin
            state_nxt  = LOAD;
            wr_cnt_nxt = '0;
        end else if (state == LOAD && beat) begin
            if (bad) begin
                state_nxt = ERR;
            end else begin
                wr_en = 1'b1;
                if (s_axis_tlast)  state_nxt = at_end ? DONE : ERR;
                else if (at_end)   state_nxt = ERR;
                else               wr_cnt_nxt = wr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_cnt] <= s_axis_tdata;
    end

    // Non-blocking read of mem gives read-first behaviour on a same-address write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= ({1'b0, rd_addr} < DEPTH_A) ? mem[rd_addr] : '0;
        end
    end
endmodule

// File: tb/tb_tansig_table_loader.sv
// Self-checking bench for tansig_table_loader: randomized loads/reads against a table-level model.
// Expectations follow TANSIG_LOADER_CHECK_EN when the bench is built with it.
module tb_tansig_table_loader;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 201;
    localparam int ADDR_W = 8;
`ifdef TANSIG_LOADER_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_load = 1'b0;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tlast = 1'b0;
    logic              s_axis_tready;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              table_ready;
    logic              load_err;

    tansig_table_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start_load(start_load),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .table_ready(table_ready), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] ref_mem   [DEPTH];
    bit          ref_known [DEPTH];
    logic [31:0] beats [$];

    // Real -> IEEE-754 single for non-negative values below 2.0.
    function automatic logic [31:0] fp32(input real x);
        real m;
        int  e, f;
        if (x <= 0.0) return 32'h0;
        m = x;
        e = 127;
        while (m < 1.0)  begin m = m * 2.0; e--; end
        while (m >= 2.0) begin m = m / 2.0; e++; end
        f = int'((m - 1.0) * 8388608.0);
        if (f >= 8388608) begin f = 0; e++; end
        return {1'b0, 8'(e), 23'(f)};
    endfunction

    task automatic build_beats(input int n, input real scale);
        beats.delete();
        for (int i = 0; i < n; i++) beats.push_back(fp32(scale * $tanh(0.04 * i)));
    endtask

    task automatic pulse_start(input bit with_beat);
        @(negedge clk);
        start_load = 1'b1;
        if (with_beat) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'hDEADBEEF;
            s_axis_tlast  = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        start_load    = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Offers beats with random gaps; stops when all are taken or the loader holds off.
    task automatic drive_load(input int n, input int last_at, output int acc);
        int   j, idle, cyc;
        logic tr;
        j = 0; idle = 0; cyc = 0;
        while (j < n && idle < 4 && cyc < 3000) begin
            if (cyc > 0) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
            end else begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = beats[j];
                s_axis_tlast  = (j == last_at);
            end
            tr = s_axis_tready;
            @(posedge clk);
            if (s_axis_tvalid && tr)  j++;
            else if (s_axis_tvalid)   idle++;
            cyc++;
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        n_chk++;
        if (cyc >= 3000) begin
            n_fail++;
            $display("FAIL load_timeout: accepted %0d beats in %0d cycles", j, cyc);
        end
        acc = j;
    endtask

    // Full load with model update; outcome computed from the table rules on the beat list.
    task automatic run_load(input string name, input int n, input int last_at,
                            input int bad_idx, input logic [31:0] bad_val, input real scale);
        int stop, nwr, exp_acc, acc;
        bit ok;
        build_beats(n, scale);
        if (bad_idx >= 0) beats[bad_idx] = bad_val;
        pulse_start(1'b1);
        drive_load(n, last_at, acc);
        stop    = (last_at >= 0 && last_at < DEPTH - 1) ? last_at : DEPTH - 1;
        ok      = (last_at == DEPTH - 1);
        nwr     = stop + 1;
        exp_acc = stop + 1;
        if (CHECK) begin
            for (int k = 0; k <= stop; k++) begin
                if (beats[k][31] || beats[k] > 32'h3F800000 || (k > 0 && beats[k] < beats[k-1])) begin
                    exp_acc = k + 1;
                    nwr     = k;
                    ok      = 1'b0;
                    break;
                end
            end
        end
        for (int k = 0; k < nwr; k++) begin
            ref_mem[k]   = beats[k];
            ref_known[k] = 1'b1;
        end
        n_chk++;
        if (acc !== exp_acc) begin
            n_fail++;
            $display("FAIL %s accepted_beats: got %0d expected %0d", name, acc, exp_acc);
        end
        n_chk++;
        if (table_ready !== ok) begin
            n_fail++;
            $display("FAIL %s table_ready: got %b expected %b", name, table_ready, ok);
        end
        n_chk++;
        if (load_err !== !ok) begin
            n_fail++;
            $display("FAIL %s load_err: got %b expected %b", name, load_err, !ok);
        end
        n_chk++;
        if (s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s tready_after: got %b expected 0", name, s_axis_tready);
        end
    endtask

    // Random reads; each result checked the cycle after its request.
    task automatic test_reads(input string name, input int n, input int force_addr);
        bit          p_en, hold_known;
        logic [7:0]  p_addr;
        logic [31:0] hold, exp_d;
        p_en = 0; hold_known = 0; hold = '0; p_addr = '0;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_chk++;
                if (rd_valid !== p_en) begin
                    n_fail++;
                    $display("FAIL %s rd_valid: got %b expected %b", name, rd_valid, p_en);
                end
                if (p_en) begin
                    hold_known = (p_addr >= DEPTH) || ref_known[p_addr];
                    exp_d      = (p_addr >= DEPTH) ? 32'h0 : ref_mem[p_addr];
                    hold       = exp_d;
                end
                if (hold_known) begin
                    n_chk++;
                    if (rd_data !== hold) begin
                        n_fail++;
                        $display("FAIL %s rd_data[%0d]: got %h expected %h", name, p_addr, rd_data, hold);
                    end
                end
            end
            if (k == n) begin
                rd_en = 1'b0;
            end else if (force_addr >= 0 && k == 0) begin
                rd_en   = 1'b1;
                rd_addr = 8'(force_addr);
            end else begin
                rd_en   = ($urandom_range(0, 3) != 0);
                rd_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(DEPTH, 255))
                                                      : 8'($urandom_range(0, DEPTH - 1));
            end
            p_en   = rd_en;
            p_addr = rd_addr;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({s_axis_tready, rd_valid, table_ready, load_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {s_axis_tready, rd_valid, table_ready, load_err});
        end
        n_chk++;
        if (rd_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rd_data: got %h expected 00000000", rd_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_load;
        run_load("full", DEPTH, DEPTH - 1, -1, 32'h0, 1.0);
        @(negedge clk);
        rd_en = 1'b1; rd_addr = 8'd25;
        @(negedge clk);
        rd_en = 1'b0;
        n_chk++;
        if (rd_data !== 32'h3F42F7D6 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_tanh1: got %h/%b expected 3f42f7d6/1", rd_data, rd_valid);
        end
        test_reads("full_reads", 40, -1);
    endtask

    task automatic test_oob_read;
        test_reads("oob", 4, 255);
    endtask

    task automatic test_short_table;
        run_load("short", 100, 99, -1, 32'h0, real'($urandom_range(500, 999)) / 1000.0);
        test_reads("short_reads", 30, 99);
    endtask

    task automatic test_long_table;
        run_load("long", DEPTH + 1, -1, -1, 32'h0, real'($urandom_range(500, 999)) / 1000.0);
        test_reads("long_reads", 30, 200);
    endtask

    task automatic test_reset_mid_load;
        int acc;
        build_beats(50, real'($urandom_range(500, 999)) / 1000.0);
        pulse_start(1'b1);
        drive_load(50, -1, acc);
        for (int k = 0; k < acc; k++) begin
            ref_mem[k]   = beats[k];
            ref_known[k] = 1'b1;
        end
        n_chk++;
        if (s_axis_tready !== 1'b1 || acc !== 50) begin
            n_fail++;
            $display("FAIL midrst_loading: got tready=%b acc=%0d expected 1/50", s_axis_tready, acc);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({s_axis_tready, table_ready, load_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_flags: got %b expected 000", {s_axis_tready, table_ready, load_err});
        end
        @(negedge clk);
        rst = 1'b0;
        run_load("reload", DEPTH, DEPTH - 1, -1, 32'h0, 1.0);
    endtask

    task automatic test_back_to_back;
        int acc;
        build_beats(30, 0.6);
        pulse_start(1'b1);
        drive_load(30, -1, acc);
        for (int k = 0; k < acc; k++) begin
            ref_mem[k]   = beats[k];
            ref_known[k] = 1'b1;
        end
        run_load("restart", DEPTH, DEPTH - 1, -1, 32'h0, real'($urandom_range(500, 999)) / 1000.0);
        test_reads("restart_reads", 30, 0);
    endtask

    task automatic test_bad_value;
        run_load("badval", DEPTH, DEPTH - 1, 3, 32'hBF800000, 1.0);
        test_reads("badval_reads", 20, 3);
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            ref_mem[k]   = '0;
            ref_known[k] = 1'b0;
        end
        test_reset;
        test_full_load;
        test_oob_read;
        test_short_table;
        test_long_table;
        test_reset_mid_load;
        test_back_to_back;
        test_bad_value;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
